niossoc_led_pio: RTL
====================

Name: niossoc_led_pio

Overview:
- Parametrised Avalon-MM output PIO for board LEDs; next generation of the single-register SoC LED port.
- Adds configurable width and reset value, atomic bit set/clear registers, and a per-bit hardware blink engine driven by a prescaled timebase.
- Sits on the Nios system interconnect as a zero-wait-state slave; out_port drives LED pins directly.

Parameters:
- WIDTH, 27, number of out_port bits (1..32).
- RESET_VALUE, 0, DATA register value after reset (WIDTH bits).
- PRESCALE, 50000, clk cycles per blink tick (>=1); 1 ms at 50 MHz.
- PERIOD_W, 16, width of the PERIOD register.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  word address of register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits [WIDTH-1:0] used.
- readdata  out  32  read data, combinational from address; upper bits 0.
- out_port  out  WIDTH  LED drive.

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-low (reset_n).
- Write = chipselect & ~write_n, sampled at rising clk. Reads are zero-wait: readdata = f(address) in the same cycle, with no side effects.
- Register map (word address):
  - 0 DATA, RW.
  - 1 reserved, reads 0.
  - 2 BLINK_EN, RW, per-bit.
  - 3 PERIOD, RW, half-period in ticks.
  - 4 OUTSET, WO, reads 0: DATA <= DATA | wd.
  - 5 OUTCLEAR, WO, reads 0: DATA <= DATA & ~wd.
  - 6 STATUS, RO: bit0 = phase, bit1 = tick_pending (prescaler at terminal count).
  - 7 reserved, reads 0.
  - Writes to RO or reserved addresses are ignored.
- Reset values:
  - DATA = RESET_VALUE; BLINK_EN = 0; PERIOD = 0.
  - phase = 1; prescaler = 0; half-period counter = 0.
  - out_port = RESET_VALUE.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick asserts for one cycle when count = PRESCALE-1.
  - PRESCALE = 1 gives a tick every cycle.
- Half-period counter:
  - Advances only on tick.
  - When it reaches PERIOD-1 on a tick: wraps to 0 and phase toggles.
  - PERIOD = 0: counter and prescaler held at 0, phase forced to 1 (blink disabled).
- PERIOD write: prescaler, counter and phase all reload to 0/0/1 in the same cycle. This takes priority over a coincident tick.
- out_port = DATA & ~(BLINK_EN & {WIDTH{~phase}}).
  - Bits with BLINK_EN = 1 follow DATA during phase 1 and are 0 during phase 0.
  - out_port is combinational from flops only, so any register write is visible on out_port in the cycle after the write edge.
- BLINK_EN write does not disturb the phase or counters.
- Only one access per cycle on the single Avalon port, so no set/clear collision is possible.
- Reset mid-blink returns everything to reset values immediately (asynchronous); counting restarts from 0 after deassertion.
- Arithmetic: counters are unsigned, with widths clog2(PRESCALE) and PERIOD_W. There is no overflow, because the terminal compare always precedes the natural wrap.

Decomposition:
- Shared package niossoc_pio_pkg:
  - Register address constants: ADDR_DATA = 0, ADDR_BLINK_EN = 2, ADDR_PERIOD = 3, ADDR_OUTSET = 4, ADDR_OUTCLEAR = 5, ADDR_STATUS = 6.
  - STATUS bit indices.
- Sub-module niossoc_led_blink_timer (params PRESCALE, PERIOD_W):
  - Inputs: clk, reset_n, period, restart.
  - Outputs: phase, tick.
  - Holds the prescaler and half-period counter.
- Top level holds the register file, read mux and output masking.

Test Plan:
- Reset, then read 0 and check out_port with RESET_VALUE = 27'h155 -> readdata = 32'h155 and out_port = 27'h155; reads of addresses 1, 2, 3, 7 return 0.
- Write DATA = 32'hFFFF_FFFF (WIDTH = 27) -> next cycle out_port = 27'h7FF_FFFF, read 0 = 32'h07FF_FFFF. Then OUTCLEAR = 32'h0F -> DATA = 27'h7FF_FFF0. Then OUTSET = 32'h3 -> DATA = 27'h7FF_FFF3.
- With PRESCALE = 4, DATA = 27'hF, BLINK_EN = 27'h3, write PERIOD = 2 -> out_port toggles between 27'hF and 27'hC every 8 cycles; STATUS bit0 follows phase.
- Write PERIOD mid-phase-0 -> next cycle phase = 1 and out_port = DATA; first toggle occurs exactly PERIOD × PRESCALE cycles later.
- Write PERIOD = 0 while blinking -> out_port = DATA permanently; STATUS = 32'h1.
- Assert reset_n low asynchronously mid-blink -> out_port = RESET_VALUE with no clk edge; after release, BLINK_EN = 0 and PERIOD = 0 read back.

Source files
------------

// File: rtl/niossoc_pio_pkg.sv
// Purpose: shared register map and STATUS bit layout for the LED PIO.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
//
// Contents:
//   ADDR_*            word addresses of the Avalon-MM registers
//   STATUS_*_BIT      bit positions inside the STATUS register
package niossoc_pio_pkg;

    // Word addresses on the 3-bit Avalon address bus.
    // Addresses 1 and 7 are reserved and read as zero.
    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd2;
    localparam logic [2:0] ADDR_PERIOD   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;

    // STATUS register layout.
    localparam int STATUS_PHASE_BIT = 0;  // current blink phase (1 = LEDs lit)
    localparam int STATUS_TICK_BIT  = 1;  // prescaler sits at its terminal count

endpackage : niossoc_pio_pkg

// File: rtl/niossoc_led_blink_timer.sv
// Purpose: prescaled timebase plus half-period counter that produces the blink phase.
// Latency: restart or PERIOD change takes effect on the first clock edge after it is seen.
// Backpressure: none; free-running, never stalls.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   period   in   half-period in ticks; 0 disables blinking
//   restart  in   one-cycle pulse: reload prescaler/counter to 0 and phase to 1
//   phase    out  1 = blinking bits lit, 0 = blinking bits dark
//   tick     out  prescaler at terminal count (only while blinking is enabled)
module niossoc_led_blink_timer #(
    parameter int PRESCALE = 50000,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic                phase,
    output logic                tick
);

    // A prescale of 1 still needs a 1-bit counter; it simply never leaves 0.
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]     presc_cnt;
    logic [PERIOD_W-1:0] half_cnt;
    logic                enabled;
    logic                half_done;

    assign enabled   = (period != '0);
    // Gated with enabled so a disabled timer never reports a pending tick,
    // even with PRESCALE = 1 where the held count equals the terminal count.
    assign tick      = enabled && (presc_cnt == PS_LAST);
    assign half_done = (half_cnt == period - PERIOD_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt <= '0;
            half_cnt  <= '0;
            phase     <= 1'b1;
        end else if (restart || !enabled) begin
            // A PERIOD write wins over a tick landing in the same cycle.
            presc_cnt <= '0;
            half_cnt  <= '0;
            phase     <= 1'b1;
        end else begin
            // Terminal compares come first, so neither counter ever wraps naturally.
            if (tick) begin
                presc_cnt <= '0;
                if (half_done) begin
                    half_cnt <= '0;
                    phase    <= ~phase;
                end else begin
                    half_cnt <= half_cnt + PERIOD_W'(1);
                end
            end else begin
                presc_cnt <= presc_cnt + PS_W'(1);
            end
        end
    end

endmodule : niossoc_led_blink_timer

// File: rtl/niossoc_led_pio.sv
// Purpose: Avalon-MM LED output PIO with set/clear aliases and per-bit hardware blink.
// Latency: zero-wait reads; a write shows on out_port in the cycle after its clock edge.
// Backpressure: none; zero-wait-state slave that accepts every access.
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   register word address
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   write data, bits [WIDTH-1:0] used
//   readdata    out  register contents selected by address, upper bits zero
//   out_port    out  LED drive
module niossoc_led_pio
    import niossoc_pio_pkg::*;
#(
    parameter int               WIDTH       = 27,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               PRESCALE    = 50000,
    parameter int               PERIOD_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]    data_q;
    logic [WIDTH-1:0]    blink_en_q;
    logic [PERIOD_W-1:0] period_q;

    logic                wr_en;
    logic [WIDTH-1:0]    wr_dat;
    logic                restart;
    logic                phase;
    logic                tick;

    // Only the low bits of writedata carry register content; the rest are
    // collected here so the unused bits are visibly intentional.
    logic                unused_wd;
    assign unused_wd = ^writedata;

    assign wr_en   = chipselect & ~write_n;
    assign wr_dat  = writedata[WIDTH-1:0];
    assign restart = wr_en && (address == ADDR_PERIOD);

    // ------------------------------------------------------------------
    // Register file. Writes to STATUS and reserved words fall through.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            blink_en_q <= '0;
            period_q   <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:     data_q     <= wr_dat;
                ADDR_BLINK_EN: blink_en_q <= wr_dat;
                ADDR_PERIOD:   period_q   <= writedata[PERIOD_W-1:0];
                ADDR_OUTSET:   data_q     <= data_q | wr_dat;
                ADDR_OUTCLEAR: data_q     <= data_q & ~wr_dat;
                default:       ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Blink timebase
    // ------------------------------------------------------------------
    niossoc_led_blink_timer #(
        .PRESCALE (PRESCALE),
        .PERIOD_W (PERIOD_W)
    ) u_blink_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_q),
        .restart (restart),
        .phase   (phase),
        .tick    (tick)
    );

    // ------------------------------------------------------------------
    // Read mux: purely combinational, no read side effects.
    // ------------------------------------------------------------------
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0]    = data_q;
            ADDR_BLINK_EN: readdata[WIDTH-1:0]    = blink_en_q;
            ADDR_PERIOD:   readdata[PERIOD_W-1:0] = period_q;
            ADDR_STATUS: begin
                readdata[STATUS_PHASE_BIT] = phase;
                readdata[STATUS_TICK_BIT]  = tick;
            end
            default:       ;
        endcase
    end

    // Blinking bits are blanked during phase 0; everything else follows DATA.
    assign out_port = data_q & ~(blink_en_q & {WIDTH{~phase}});

endmodule : niossoc_led_pio
